blit_walker: RTL

- Command sequencer that walks a blit rectangle pixel by pixel. It issues one pipeline token per destination pixel to the blitter read/colour stages: dst address, src address, is_mem, is_text, bit_index.
- Sits between the blitter register file (command source) and the source-read stage that feeds the colour stage.
- Supports three operations:
  - solid fill
  - memory copy (8bpp)
  - 1bpp text/glyph expansion

---
 rtl/blit_walker.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/blit_walker.sv
// rtl/blit_walker.sv - blit rectangle walker issuing one token per destination pixel
//
// Accepts a FILL / COPY / TEXT command from the blitter register file and
// walks the rectangle row-major, presenting one token per pixel to the
// source-read stage.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   cmd_*                 command channel (valid/ready), op, addresses, size, strides
//   abort                 terminate the command in progress
//   out_*                 token channel (valid/ready) with dst/src address, flags, glyph bit
//   busy                  command in progress
//   done                  one-cycle completion / abort pulse
module blit_walker #(
    parameter int ADDR_W = 26,
    parameter int DIM_W  = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst_addr,
    input  logic [ADDR_W-1:0] cmd_src_addr,
    input  logic [DIM_W-1:0]  cmd_width,
    input  logic [DIM_W-1:0]  cmd_height,
    input  logic [15:0]       cmd_dst_stride,
    input  logic [15:0]       cmd_src_stride,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_dst_address,
    output logic [ADDR_W-1:0] out_src_address,
    output logic              out_is_mem,
    output logic              out_is_text,
    output logic [2:0]        out_bit_index,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_COPY = 2'd1;
    localparam logic [1:0] OP_TEXT = 2'd2;

    state_t state;
    state_t state_next;

    logic [1:0]        op;
    logic [DIM_W-1:0]  width;
    logic [DIM_W-1:0]  height;
    logic [15:0]       dst_stride;
    logic [15:0]       src_stride;
    logic [DIM_W-1:0]  x;
    logic [DIM_W-1:0]  y;
    logic [ADDR_W-1:0] row_dst;
    logic [ADDR_W-1:0] row_src;

    logic              accept;
    logic              xfer;
    logic              row_end;
    logic              last_token;
    logic [DIM_W-1:0]  x_last;
    logic [DIM_W-1:0]  y_last;
    logic [ADDR_W-1:0] x_ext;
    logic [ADDR_W-1:0] x_byte_ext;
    logic [ADDR_W-1:0] dst_step;
    logic [ADDR_W-1:0] src_step;

    assign accept     = (state == S_IDLE) && cmd_valid;
    assign xfer       = (state == S_RUN) && out_ready;
    assign x_last     = width - 1'b1;
    assign y_last     = height - 1'b1;
    assign row_end    = (x == x_last);
    assign last_token = row_end && (y == y_last);

    // Pixel offset within the row, and its byte offset for 1bpp glyph rows.
    assign x_ext      = {{(ADDR_W-DIM_W){1'b0}}, x};
    assign x_byte_ext = {{(ADDR_W-DIM_W+3){1'b0}}, x[DIM_W-1:3]};

    // Strides are signed; sign extension lets the modular add walk backwards.
    assign dst_step   = {{(ADDR_W-16){dst_stride[15]}}, dst_stride};
    assign src_step   = {{(ADDR_W-16){src_stride[15]}}, src_stride};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if ((cmd_width == '0) || (cmd_height == '0)) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // A transfer coinciding with abort still counts; either way we finish.
                if (abort || (out_ready && last_token)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Walk counters only move on a transfer, so a stalled token stays put.
    always_ff @(posedge clock) begin
        if (reset) begin
            op         <= '0;
            width      <= '0;
            height     <= '0;
            dst_stride <= '0;
            src_stride <= '0;
            x          <= '0;
            y          <= '0;
            row_dst    <= '0;
            row_src    <= '0;
        end else if (accept) begin
            op         <= cmd_op;
            width      <= cmd_width;
            height     <= cmd_height;
            dst_stride <= cmd_dst_stride;
            src_stride <= cmd_src_stride;
            x          <= '0;
            y          <= '0;
            row_dst    <= cmd_dst_addr;
            row_src    <= cmd_src_addr;
        end else if (xfer) begin
            if (row_end) begin
                x       <= '0;
                y       <= y + 1'b1;
                row_dst <= row_dst + dst_step;
                row_src <= row_src + src_step;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    always_comb begin
        out_valid       = 1'b0;
        out_dst_address = '0;
        out_src_address = '0;
        out_is_mem      = 1'b0;
        out_is_text     = 1'b0;
        out_bit_index   = 3'd0;
        if (state == S_RUN) begin
            out_valid       = 1'b1;
            out_dst_address = row_dst + x_ext;
            case (op)
                OP_COPY: begin
                    out_is_mem      = 1'b1;
                    out_src_address = row_src + x_ext;
                end
                OP_TEXT: begin
                    out_is_mem      = 1'b1;
                    out_is_text     = 1'b1;
                    out_src_address = row_src + x_byte_ext;
                    out_bit_index   = x[2:0];
                end
                // FILL and the reserved opcode share the constant-source path.
                default: out_src_address = row_src;
            endcase
        end
    end

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

endmodule
